// File: rtl/vector_register_file.sv
// Scalar/vector register file: two combinational read ports, one masked write port,
// optional write-to-read bypass and a clear sweep that zeroes storage after reset or on request.

module vrf_lane #(
  parameter int LANE_W   = 32,
  parameter int NUM_VREG = 8,
  parameter int VIDX_W   = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [VIDX_W-1:0] i_widx,
  input  logic [LANE_W-1:0] i_wd,
  input  logic              i_blank,
  input  logic [LANE_W-1:0] i_bwd,
  input  logic              i_vsel1,
  input  logic              i_byp1,
  input  logic [VIDX_W-1:0] i_ridx1,
  input  logic [LANE_W-1:0] i_sval1,
  input  logic              i_vsel2,
  input  logic              i_byp2,
  input  logic [VIDX_W-1:0] i_ridx2,
  input  logic [LANE_W-1:0] i_sval2,
  output logic [LANE_W-1:0] o_rd1,
  output logic [LANE_W-1:0] o_rd2
);
  logic [LANE_W-1:0] r_mem [NUM_VREG];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_widx] <= i_wd;

  assign o_rd1 = i_blank ? '0 : !i_vsel1 ? i_sval1 : i_byp1 ? i_bwd : r_mem[i_ridx1];
  assign o_rd2 = i_blank ? '0 : !i_vsel2 ? i_sval2 : i_byp2 ? i_bwd : r_mem[i_ridx2];
endmodule

module vector_register_file #(
  parameter int LANE_W   = 32,
  parameter int LANES    = 4,
  parameter int ADDR_W   = 5,
  parameter int NUM_VREG = 8,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    we3,
  input  logic [LANES-1:0]        wmask,
  input  logic [ADDR_W-1:0]       a1,
  input  logic [ADDR_W-1:0]       a2,
  input  logic [ADDR_W-1:0]       a3,
  input  logic [LANES*LANE_W-1:0] wd3,
  output logic [LANES*LANE_W-1:0] rd1,
  output logic [LANES*LANE_W-1:0] rd2
);
  localparam int NUM_SREG = (1 << ADDR_W) - NUM_VREG;
  localparam int SWEEP    = (NUM_SREG > NUM_VREG) ? NUM_SREG : NUM_VREG;
  localparam int IDX_W    = (SWEEP > 1) ? $clog2(SWEEP) : 1;
  localparam int SIDX_W   = (NUM_SREG > 1) ? $clog2(NUM_SREG) : 1;
  localparam int VIDX_W   = (NUM_VREG > 1) ? $clog2(NUM_VREG) : 1;
  localparam bit BYP_EN   = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] VBASE_A  = ADDR_W'(NUM_SREG);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SWEEP - 1);
  localparam logic [IDX_W:0]    NS_LIM   = (IDX_W+1)'(NUM_SREG);
  localparam logic [IDX_W:0]    NV_LIM   = (IDX_W+1)'(NUM_VREG);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;

  logic [LANES-1:0][LANE_W-1:0] w_wd, w_rd1, w_rd2;
  logic [LANE_W-1:0] r_sreg [NUM_SREG];

  logic              w_clr, w_clr_s, w_clr_v, w_wr;
  logic              w_a1_vec, w_a2_vec, w_a3_vec, w_byp1, w_byp2;
  logic [VIDX_W-1:0] w_vi1, w_vi2, w_vi3, w_v_widx;
  logic [SIDX_W-1:0] w_s_widx;
  logic              w_s_we;
  logic [LANE_W-1:0] w_s_wd, w_sv1, w_sv2;

  // ---- clear sequencer ----
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE:
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      S_CLEAR:
        if (r_idx == IDX_LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CLEAR);
  end

  // ---- address decode ----
  assign w_wd     = wd3;
  assign w_a1_vec = (a1 >= VBASE_A);
  assign w_a2_vec = (a2 >= VBASE_A);
  assign w_a3_vec = (a3 >= VBASE_A);

  // VBASE is a multiple of NUM_VREG, so the vreg index is just the low address bits.
  if (NUM_VREG > 1) begin : g_vidx
    assign w_vi1 = a1[VIDX_W-1:0];
    assign w_vi2 = a2[VIDX_W-1:0];
    assign w_vi3 = a3[VIDX_W-1:0];
  end else begin : g_vidx_one
    assign w_vi1 = '0;
    assign w_vi2 = '0;
    assign w_vi3 = '0;
  end

  assign w_clr   = busy;
  assign w_clr_s = w_clr & ({1'b0, r_idx} < NS_LIM);
  assign w_clr_v = w_clr & ({1'b0, r_idx} < NV_LIM);
  assign w_wr    = we3 & ~busy & (a3 != '0);
  assign w_byp1  = BYP_EN & w_wr & (a1 == a3);
  assign w_byp2  = BYP_EN & w_wr & (a2 == a3);

  // ---- scalar storage ----
  assign w_s_we   = w_clr_s | (w_wr & ~w_a3_vec);
  assign w_s_widx = w_clr ? r_idx[SIDX_W-1:0] : a3[SIDX_W-1:0];
  assign w_s_wd   = w_clr ? '0 : w_wd[0];

  always_ff @(posedge clk)
    if (w_s_we) r_sreg[w_s_widx] <= w_s_wd;

  assign w_sv1 = (a1 == '0) ? '0 : w_byp1 ? w_wd[0] : r_sreg[a1[SIDX_W-1:0]];
  assign w_sv2 = (a2 == '0) ? '0 : w_byp2 ? w_wd[0] : r_sreg[a2[SIDX_W-1:0]];

  // ---- vector storage, one slice per lane ----
  assign w_v_widx = w_clr ? r_idx[VIDX_W-1:0] : w_vi3;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vrf_lane #(.LANE_W(LANE_W), .NUM_VREG(NUM_VREG), .VIDX_W(VIDX_W)) u_lane (
      .clk     (clk),
      .i_we    (w_clr_v | (w_wr & w_a3_vec & wmask[gi])),
      .i_widx  (w_v_widx),
      .i_wd    (w_clr ? '0 : w_wd[gi]),
      .i_blank (busy),
      .i_bwd   (w_wd[gi]),
      .i_vsel1 (w_a1_vec),
      .i_byp1  (w_byp1 & wmask[gi]),
      .i_ridx1 (w_vi1),
      .i_sval1 (w_sv1),
      .i_vsel2 (w_a2_vec),
      .i_byp2  (w_byp2 & wmask[gi]),
      .i_ridx2 (w_vi2),
      .i_sval2 (w_sv2),
      .o_rd1   (w_rd1[gi]),
      .o_rd2   (w_rd2[gi])
    );
  end

  assign rd1 = w_rd1;
  assign rd2 = w_rd2;
endmodule

// File: tb/tb_vector_register_file.sv
// Bench for vector_register_file: vector table, clear/reset sequences, a wide
// configuration, and random traffic against an array-based reference model.

module tb_vector_register_file;
  localparam int LW = 32, LN = 4, NS = 24, NV = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           clr_req, we3, busy, nb_busy;
  logic [3:0]     wmask;
  logic [4:0]     a1, a2, a3;
  logic [127:0]   wd3, rd1, rd2, nb_rd1, nb_rd2;

  logic           x_clr, x_we, x_busy;
  logic [7:0]     x_mask;
  logic [5:0]     x_a1, x_a2, x_a3;
  logic [255:0]   x_wd, x_rd1, x_rd2;

  vector_register_file dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy), .we3(we3), .wmask(wmask),
    .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .rd1(rd1), .rd2(rd2));

  vector_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(nb_busy), .we3(we3), .wmask(wmask),
    .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .rd1(nb_rd1), .rd2(nb_rd2));

  vector_register_file #(.LANES(8), .NUM_VREG(4), .ADDR_W(6)) dut_x (
    .clk(clk), .rst_n(rst_n), .clr_req(x_clr), .busy(x_busy), .we3(x_we), .wmask(x_mask),
    .a1(x_a1), .a2(x_a2), .a3(x_a3), .wd3(x_wd), .rd1(x_rd1), .rd2(x_rd2));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- reference model: plain arrays plus a remaining-busy-cycles counter ----
  logic [31:0]  ms [NS];
  logic [127:0] mv [NV];
  int           rem;

  task automatic mzero();
    for (int i = 0; i < NS; i++) ms[i] = '0;
    for (int i = 0; i < NV; i++) mv[i] = '0;
  endtask

  function automatic logic [127:0] post_wr(input int a, input logic [127:0] old);
    logic [127:0] r;
    if (a >= NS) begin
      r = old;
      for (int i = 0; i < LN; i++) if (wmask[i]) r[i*LW +: LW] = wd3[i*LW +: LW];
    end else begin
      r = {LN{wd3[LW-1:0]}};
    end
    return r;
  endfunction

  function automatic logic [127:0] mread(input int a, input bit byp);
    logic [127:0] old;
    if (!rst_n || rem > 0 || a == 0) return '0;
    old = (a >= NS) ? mv[a-NS] : {LN{ms[a]}};
    if (byp && we3 && a3 != 0 && a == int'(a3)) return post_wr(a, old);
    return old;
  endfunction

  task automatic model_edge();
    int ia3;
    ia3 = int'(a3);
    if (!rst_n) begin mzero(); rem = NS; return; end
    if (rem > 0) begin rem--; return; end
    if (we3 && ia3 != 0) begin
      if (ia3 >= NS) mv[ia3-NS] = post_wr(ia3, mv[ia3-NS]);
      else           ms[ia3]    = wd3[LW-1:0];
    end
    if (clr_req) begin mzero(); rem = NS; end
  endtask

  // Entered at a negedge with inputs applied: check, clock, update model.
  task automatic cyc();
    #1;
    chk("rd1",    rd1,    mread(int'(a1), 1'b1));
    chk("rd2",    rd2,    mread(int'(a2), 1'b1));
    chk("nb_rd1", nb_rd1, mread(int'(a1), 1'b0));
    chk("nb_rd2", nb_rd2, mread(int'(a2), 1'b0));
    chk("busy",    busy,    (rem > 0) || !rst_n);
    chk("nb_busy", nb_busy, (rem > 0) || !rst_n);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we3 = 0; clr_req = 0; wmask = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    x_we = 0; x_clr = 0; x_mask = '0; x_a1 = '0; x_a2 = '0; x_a3 = '0; x_wd = '0;
  endtask

  task automatic count_busy(output int nm, output int nx);
    nm = 0; nx = 0;
    for (int k = 0; k < 200 && (busy || x_busy); k++) begin
      if (busy) nm++;
      if (x_busy) nx++;
      cyc();
    end
  endtask

  typedef struct {
    logic         we;
    logic [3:0]   m;
    logic [4:0]   a1, a2, a3;
    logic [127:0] wd, e1, e2, enb;
  } vec_t;

  initial begin
    vec_t tv [11];
    logic [127:0] db, v1234, vmix, vlo, ones, rep;
    logic [255:0] pat;
    int nm, nx, n;

    db    = {4{32'hDEADBEEF}};
    v1234 = {32'h4, 32'h3, 32'h2, 32'h1};
    vmix  = {32'h4, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF};
    vlo   = {64'h0, 32'hCCCCCCCC, 32'hDDDDDDDD};
    ones  = '1;
    rep   = {4{32'h12345678}};
    tv[0]  = '{1'b0, 4'h0, 5'd5,  5'd31, 5'd0,  128'h0, 128'h0, 128'h0, 128'h0};
    tv[1]  = '{1'b1, 4'h0, 5'd0,  5'd0,  5'd3,  {96'h0, 32'hDEADBEEF}, 128'h0, 128'h0, 128'h0};
    tv[2]  = '{1'b1, 4'hF, 5'd3,  5'd3,  5'd0,  ones, db, db, db};
    tv[3]  = '{1'b0, 4'h0, 5'd0,  5'd0,  5'd0,  128'h0, 128'h0, 128'h0, 128'h0};
    tv[4]  = '{1'b1, 4'hF, 5'd1,  5'd2,  5'd24, v1234, 128'h0, 128'h0, 128'h0};
    tv[5]  = '{1'b1, 4'h5, 5'd24, 5'd3,  5'd24, ones, vmix, db, v1234};
    tv[6]  = '{1'b0, 4'h0, 5'd25, 5'd24, 5'd0,  128'h0, 128'h0, vmix, 128'h0};
    tv[7]  = '{1'b1, 4'h3, 5'd25, 5'd25, 5'd25,
               {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, vlo, vlo, 128'h0};
    tv[8]  = '{1'b0, 4'h0, 5'd25, 5'd24, 5'd0,  128'h0, vlo, vmix, vlo};
    tv[9]  = '{1'b1, 4'h0, 5'd7,  5'd31, 5'd7,
               {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h12345678}, rep, 128'h0, 128'h0};
    tv[10] = '{1'b0, 4'h0, 5'd7,  5'd0,  5'd0,  128'h0, rep, 128'h0, rep};

    // ---- reset and initial sweep ----
    idle(); mzero(); rem = NS; rst_n = 0;
    @(negedge clk);
    #1;
    chk("busy_in_reset", busy, 1'b1);
    chk("x_busy_in_reset", x_busy, 1'b1);
    cyc(); cyc();
    rst_n = 1;
    count_busy(nm, nx);
    chk("sweep_len", nm, 24);
    chk("sweep_len_wide", nx, 60);

    // ---- table vectors ----
    for (int i = 0; i < 11; i++) begin
      we3 = tv[i].we; wmask = tv[i].m; a1 = tv[i].a1; a2 = tv[i].a2; a3 = tv[i].a3; wd3 = tv[i].wd;
      #1;
      chk($sformatf("tv%0d_rd1", i), rd1, tv[i].e1);
      chk($sformatf("tv%0d_rd2", i), rd2, tv[i].e2);
      chk($sformatf("tv%0d_nb_rd1", i), nb_rd1, tv[i].enb);
      cyc();
    end
    idle();

    // ---- clear request with a same-cycle write; write mid-sweep is dropped ----
    we3 = 1; a3 = 5'd10; wd3 = {4{32'h55555555}}; clr_req = 1;
    cyc();
    idle();
    chk("busy_after_clr", busy, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      if (n == 5) begin we3 = 1; a3 = 5'd24; a1 = 5'd24; wmask = 4'hF; wd3 = '1; end
      else idle();
      n++;
      cyc();
    end
    chk("clr_sweep_len", n, 24);
    idle();
    for (int a = 0; a < 32; a++) begin
      a1 = 5'(a); a2 = 5'(31 - a);
      #1;
      chk($sformatf("clr_rd_a%0d", a), rd1, 128'h0);
      cyc();
    end
    idle();

    // ---- reset in the middle of a sweep restarts it ----
    clr_req = 1;
    cyc();
    idle();
    repeat (10) cyc();
    rst_n = 0;
    #1;
    chk("busy_mid_reset", busy, 1'b1);
    chk("rd1_mid_reset", rd1, 128'h0);
    cyc(); cyc();
    rst_n = 1;
    count_busy(nm, nx);
    chk("restart_sweep_len", nm, 24);
    chk("restart_sweep_len_wide", nx, 60);

    // ---- wide configuration: vregs at 60..63 ----
    for (int i = 0; i < 8; i++) pat[i*32 +: 32] = 32'h10000000 + 32'(i);
    x_we = 1; x_a3 = 6'd60; x_mask = 8'hFF; x_wd = pat;
    cyc();
    x_we = 1; x_a3 = 6'd59; x_wd = {pat[255:32], 32'hCAFEF00D}; x_a1 = 6'd60;
    #1;
    chk("x_vreg60", x_rd1, pat);
    cyc();
    x_we = 1; x_a3 = 6'd63; x_mask = 8'h0F; x_wd = pat; x_a1 = 6'd63; x_a2 = 6'd59;
    #1;
    chk("x_byp63", x_rd1, {128'h0, pat[127:0]});
    chk("x_sreg59", x_rd2, {8{32'hCAFEF00D}});
    cyc();
    x_we = 0; x_a1 = 6'd62; x_a2 = 6'd63;
    #1;
    chk("x_vreg62", x_rd1, 256'h0);
    chk("x_vreg63", x_rd2, {128'h0, pat[127:0]});
    cyc();
    idle();

    // ---- random traffic against the model ----
    for (int k = 0; k < 400; k++) begin
      we3   = 1'($urandom_range(0, 1));
      wmask = 4'($urandom);
      a3    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      a1    = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2    = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      wd3   = {$urandom, $urandom, $urandom, $urandom};
      clr_req = ($urandom_range(0, 59) == 0);
      cyc();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_register_file.md
Name: vector_register_file

Overview:
- Parametrised scalar/vector register file for the SIMD core; replaces the fixed 32-bit-by-4-lane file.
- Two combinational read ports and one synchronous write port.
- Adds per-lane write masking, optional write-to-read bypass, and a multi-cycle clear sequencer with a busy handshake.
- The sequencer zeroes all storage after reset or on request, so storage itself needs no reset and can be inferred as RAM.

Parameters:
- LANE_W, 32, bits per lane (scalar register width).
- LANES, 4, lanes per vector register; data ports are LANES*LANE_W wide.
- ADDR_W, 5, register address width.
- NUM_VREG, 8, number of vector registers; must be a power of two and less than 2**ADDR_W.
- BYPASS, 1, 1 = a read of the address being written returns the merged new data in the same cycle; 0 = the read returns the old value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  request a full clear sweep; sampled only in IDLE.
- busy  out  1  high while the clear sweep runs; reads and writes are blocked.
- we3  in  1  write enable.
- wmask  in  LANES  per-lane write enable; used only for vector targets.
- a1  in  ADDR_W  read address, port 1.
- a2  in  ADDR_W  read address, port 2.
- a3  in  ADDR_W  write address.
- wd3  in  LANES*LANE_W  write data; lane i is bits [i*LANE_W +: LANE_W].
- rd1  out  LANES*LANE_W  read data, port 1.
- rd2  out  LANES*LANE_W  read data, port 2.

Behaviour:
- Address map:
  - VBASE = 2**ADDR_W - NUM_VREG.
  - a >= VBASE selects vreg[a - VBASE].
  - Otherwise a selects sreg[a], with NUM_SREG = VBASE entries.
  - Address 0 always reads all zeros and ignores writes.
- Read, combinational:
  - Vector target: the full register.
  - Scalar target: the LANE_W value replicated LANES times.
  - While busy=1, rd1 = rd2 = 0.
- Write, on the rising edge when we3=1 and busy=0:
  - Vector target: lane i is updated only when wmask[i]=1.
  - Scalar target: sreg gets wd3 lane 0; wmask is ignored.
- Bypass (BYPASS=1): if we3=1, busy=0, a3 != 0 and a1 == a3, rd1 shows the post-write value in the same cycle.
  - Vector target: masked lanes from wd3, other lanes from the stored value.
  - Scalar target: wd3 lane 0 replicated.
  - rd2 follows the same rule against a2.
- State machine:
  - States: IDLE and CLEAR; idx counter of width clog2(max(NUM_SREG, NUM_VREG)).
  - Async reset (rst_n=0): state=CLEAR, idx=0, busy=1 immediately.
  - CLEAR, each cycle: sreg[idx]=0 if idx < NUM_SREG; vreg[idx]=0 if idx < NUM_VREG.
  - When idx = max(NUM_SREG, NUM_VREG)-1, go to IDLE; busy drops in the following cycle.
  - Sweep length is max(NUM_SREG, NUM_VREG) cycles; 24 with defaults.
  - IDLE with clr_req=1: go to CLEAR, idx=0, busy=1 from the next cycle.
  - A write presented in that same cycle still commits, then gets cleared.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - Reset asserted mid-sweep: the sweep restarts from idx=0.
- Outputs during reset: busy=1, rd1=rd2=0.
- Storage arrays have no reset term.

Test Plan:
- Reset, then hold idle for 24 cycles → busy=1 for exactly 24 cycles after rst_n rises. Afterwards, reading a1=5 and a2=31 returns 0.
- Scalar write a3=3, wd3 lane0=32'hDEADBEEF; next cycle a1=3 → rd1 = {4{32'hDEADBEEF}}. Write to a3=0 → rd1 at a1=0 stays 0.
- Vector write a3=24, wd3 = {32'h4, 32'h3, 32'h2, 32'h1}, wmask=4'b1111. Then write a3=24 with wd3 all 32'hFFFFFFFF and wmask=4'b0101 → reading a2=24 gives {32'h4, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF}.
- Bypass: same-cycle we3=1, a3=a1=25, wmask=4'b0011, stored value 0 → rd1 shows the new low two lanes and zero upper lanes in that cycle. Repeat with BYPASS=0 → rd1 shows the old value.
- Fill registers, pulse clr_req in IDLE together with a write → busy is high for 24 cycles and a write attempted mid-sweep is dropped. Afterwards all addresses read 0.
- Assert rst_n=0 at sweep cycle 10, release → busy is high for 24 more cycles. Repeat with LANES=8, NUM_VREG=4, ADDR_W=6 → sweep takes 60 cycles and vreg addresses are 60..63.
